pseudo_rand_multi: RTL and testbench
====================================

// Module: pseudo_rand_multi
// PURPOSE
//   Multi-channel successor to the single Galois-LFSR random source: NUM_CHANNELS independent LFSRs.
//   Adds per-channel run-time reseeding, an optional valid/ready handshake, multi-step advance,
//   optional Weyl-sequence whitening and an advance counter.
//   Feeds stimulus/traffic generators (e.g. grid-network packet injectors) that need decorrelated streams.
// PARAMETERS
//   WIDTH         64  output bits per channel, 1..257; sets LFSR_WIDTH = 64 (<=64), 128 (<=128), 257 (<=257)
//   NUM_CHANNELS  4   independent LFSR channels, 1..16
//   STEPS         1   LFSR shifts per advance, 1..8
//   HANDSHAKE     0   0: free-run, rand_ready ignored; 1: advance only on rand_valid & rand_ready
//   WHITEN        0   1: XOR each channel output with the replicated 32-bit Weyl counter
// PORTS
//   clk         in   1                     clock
//   reset       in   1                     synchronous, active-high reset
//   enable      in   1                     global advance enable
//   rand_ready  in   1                     consumer ready (HANDSHAKE=1 only)
//   seed_load   in   1                     load seed_value into channel seed_chan this cycle
//   seed_chan   in   $clog2(NUM_CHANNELS)  target channel of seed_load (min width 1)
//   seed_value  in   LFSR_WIDTH            new LFSR state
//   rand_vect   out  NUM_CHANNELS*WIDTH    channel c at [c*WIDTH +: WIDTH]
//   rand_valid  out  1                     rand_vect holds a consumable value
//   step_count  out  32                    number of advances since reset, wraps at 2^32
// BEHAVIOUR
//   - Clock and reset: one clock (clk). reset is synchronous and active-high.
//   - Feedback polynomial: LFSR_POLY is zero-extended from an 8-bit constant in bits [7:0]:
//     8'h1B for 64, 8'h87 for 128, 8'hC5 for 257.
//   - One shift: s' = {s[LFSR_WIDTH-2:0],1'b0} ^ ({LFSR_WIDTH{s[LFSR_WIDTH-1]}} & LFSR_POLY).
//     An advance applies STEPS shifts combinationally, then registers the result.
//   - DEFAULT_SEED = 257'h0_7163e168_713d5431_6684e132_5cd84848_f3048b46_76874654_0c45f864_04e4684a,
//     truncated to its low LFSR_WIDTH bits.
//   - Channel c seed = DEFAULT_SEED rotated left by 17*c within LFSR_WIDTH.
//   - Reset (any cycle, including mid-operation or during seed_load):
//     lfsr[c] <= seed_c, weyl <= 0, step_count <= 0, rand_valid <= 0.
//   - rand_valid: registered.
//     Set to 1 in the first cycle after reset deassertion in which enable=1.
//     Cleared for exactly one cycle after any accepted seed_load.
//   - advance = rand_valid & enable & (HANDSHAKE ? rand_ready : 1) & ~seed_load.
//     Advance is global: every channel shifts together; step_count += 1; weyl += 32'h9E3779B9.
//   - rand_vect[c] = lfsr[c][WIDTH-1:0] ^ (WHITEN ? {9{weyl}}[WIDTH-1:0] : 0).
//     Combinational from flops: the value is visible in the same cycle rand_valid is high; latency 0.
//   - HANDSHAKE=1: while rand_valid & ~rand_ready, rand_vect and step_count stay stable.
//     enable=0 also holds state in both modes.
//   - seed_load with seed_chan < NUM_CHANNELS is accepted:
//     lfsr[seed_chan] <= (seed_value==0) ? seed_c : seed_value; the other channels hold.
//     weyl and step_count hold; rand_valid <= 0 for the next cycle, then returns to 1 if enable.
//   - seed_load with seed_chan >= NUM_CHANNELS is ignored entirely: no state change, no valid drop.
//     An advance proceeds as if seed_load were 0.
//   - Zero-state lockup: impossible, because reset seeds and loaded zeros are replaced, and a
//     nonzero state never shifts to zero.
//   - seed_load asserted on consecutive cycles: each is applied; rand_valid stays 0 until one cycle after the last.
// TESTING
//   1 WIDTH=64,CH=2,STEPS=1: release reset, enable=1
//     -> cycle after: rand_valid=1; ch0=64'h0c45f864_04e4684a; ch1=rotl(ch0 seed,17).
//   2 Same config, one advance
//     -> ch0=64'h188bf0c8_09c8d094; step_count=1.
//   3 seed_load ch0 = 64'h8000_0000_0000_0000, then advance
//     -> rand_valid low for 1 cycle; after advance ch0=64'h1B; ch1 advanced normally.
//   4 HANDSHAKE=1, rand_ready=0 for 5 cycles, then 1 for 3 cycles
//     -> rand_vect and step_count constant for 5 cycles, then step_count=3.
//   5 WHITEN=1, first advance
//     -> rand_vect[c] = lfsr[c][63:0] ^ 64'h9E3779B9_9E3779B9.
//   6 seed_load value 0; seed_chan=NUM_CHANNELS; reset asserted mid-run with STEPS=4
//     -> zero replaced by seed_c; out-of-range load is a no-op; reset restores seeds, count=0.

Source files
------------

// File: rtl/pseudo_rand_multi.sv
// Multi-channel Galois-LFSR random source with reseeding, optional handshake,
// multi-step advance, Weyl-sequence whitening and an advance counter.
module pseudo_rand_multi #(
    parameter int WIDTH        = 64,
    parameter int NUM_CHANNELS = 4,
    parameter int STEPS        = 1,
    parameter int HANDSHAKE    = 0,
    parameter int WHITEN       = 0,
    localparam int LFSR_WIDTH  = (WIDTH <= 64) ? 64 : ((WIDTH <= 128) ? 128 : 257),
    localparam int CHAN_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          rand_ready,
    input  logic                          seed_load,
    input  logic [CHAN_W-1:0]             seed_chan,
    input  logic [LFSR_WIDTH-1:0]         seed_value,
    output logic [NUM_CHANNELS*WIDTH-1:0] rand_vect,
    output logic                          rand_valid,
    output logic [31:0]                   step_count
);

    localparam logic [256:0] DEFAULT_SEED =
        257'h0_7163e168_713d5431_6684e132_5cd84848_f3048b46_76874654_0c45f864_04e4684a;
    localparam logic [7:0] POLY8 = (LFSR_WIDTH == 64)  ? 8'h1B :
                                   (LFSR_WIDTH == 128) ? 8'h87 : 8'hC5;
    localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = {{(LFSR_WIDTH-8){1'b0}}, POLY8};
    localparam logic [31:0] WEYL_INC = 32'h9E3779B9;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_shift(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], 1'b0} ^ ({LFSR_WIDTH{s[LFSR_WIDTH-1]}} & LFSR_POLY);
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] lfsr_advance(input logic [LFSR_WIDTH-1:0] s);
        logic [LFSR_WIDTH-1:0] t;
        t = s;
        for (int k = 0; k < STEPS; k++) begin
            t = lfsr_shift(t);
        end
        return t;
    endfunction

    // Per-channel seed: default seed rotated left by 17*c so channels start decorrelated.
    function automatic logic [LFSR_WIDTH-1:0] seed_of(input int c);
        logic [LFSR_WIDTH-1:0] d;
        int                    r;
        d = DEFAULT_SEED[LFSR_WIDTH-1:0];
        r = (17 * c) % LFSR_WIDTH;
        if (r == 0) begin
            return d;
        end
        return (d << r) | (d >> (LFSR_WIDTH - r));
    endfunction

    function automatic logic [WIDTH-1:0] weyl_mask(input logic [31:0] w);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = w[i % 32];
        end
        return m;
    endfunction

    logic [LFSR_WIDTH-1:0] lfsr_p1 [NUM_CHANNELS];
    logic [31:0]           weyl_p1;
    logic [31:0]           cnt_p1;
    logic                  vld_p1;

    logic                  seed_hit_p0;
    logic                  ready_ok_p0;
    logic                  advance_p0;
    logic [WIDTH-1:0]      mask_p1;

    // ---- stage p0: decode of this cycle's requests ----
    assign seed_hit_p0 = seed_load && ({{(32-CHAN_W){1'b0}}, seed_chan} < 32'(NUM_CHANNELS));
    assign ready_ok_p0 = (HANDSHAKE != 0) ? rand_ready : 1'b1;
    assign advance_p0  = vld_p1 && enable && ready_ok_p0 && !seed_hit_p0;

    // ---- stage p1: registered channel state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                lfsr_p1[c] <= seed_of(c);
            end
            weyl_p1 <= '0;
            cnt_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (seed_hit_p0) begin
            vld_p1 <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (seed_chan == CHAN_W'(c)) begin
                    lfsr_p1[c] <= (seed_value == '0) ? seed_of(c) : seed_value;
                end
            end
        end else begin
            if (enable) begin
                vld_p1 <= 1'b1;
            end
            if (advance_p0) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    lfsr_p1[c] <= lfsr_advance(lfsr_p1[c]);
                end
                weyl_p1 <= weyl_p1 + WEYL_INC;
                cnt_p1  <= cnt_p1 + 32'd1;
            end
        end
    end

    // ---- output: combinational from p1 flops, zero latency ----
    assign mask_p1 = (WHITEN != 0) ? weyl_mask(weyl_p1) : '0;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
        assign rand_vect[c*WIDTH +: WIDTH] = lfsr_p1[c][WIDTH-1:0] ^ mask_p1;
    end

    assign rand_valid = vld_p1;
    assign step_count = cnt_p1;

endmodule

// File: tb/tb_pseudo_rand_multi.sv
// Scoreboard bench: two differently configured pseudo_rand_multi instances
// driven by shared stimulus and checked against a queue-fed reference model.
module tb_pseudo_rand_multi;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         rand_ready;
    logic         seed_load;
    logic [1:0]   seed_chan;
    logic [63:0]  seed_value;
    logic [191:0] a_vect;
    logic [143:0] b_vect;
    logic         a_valid, b_valid;
    logic [31:0]  a_cnt, b_cnt;

    int checks = 0;
    int fails  = 0;

    // A: full width, handshake, single step. B: narrow output, free-run, 4 steps, whitened.
    pseudo_rand_multi #(.WIDTH(64), .NUM_CHANNELS(3), .STEPS(1), .HANDSHAKE(1), .WHITEN(0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .rand_ready(rand_ready),
        .seed_load(seed_load), .seed_chan(seed_chan), .seed_value(seed_value),
        .rand_vect(a_vect), .rand_valid(a_valid), .step_count(a_cnt));

    pseudo_rand_multi #(.WIDTH(48), .NUM_CHANNELS(3), .STEPS(4), .HANDSHAKE(0), .WHITEN(1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .rand_ready(rand_ready),
        .seed_load(seed_load), .seed_chan(seed_chan), .seed_value(seed_value),
        .rand_vect(b_vect), .rand_valid(b_valid), .step_count(b_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [191:0] v;
        logic [31:0]  n;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic [63:0] m_lfsr [2][3];
    logic [31:0] m_weyl [2];
    logic [31:0] m_cnt  [2];
    bit          m_vld  [2];

    // Multiply by x in GF(2)[x] modulo x^64 + x^4 + x^3 + x + 1.
    function automatic logic [63:0] mul_x(input logic [63:0] s);
        return (s << 1) ^ (s[63] ? 64'h1B : 64'h0);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] v, input int r);
        if (r == 0) return v;
        return (v << r) | (v >> (64 - r));
    endfunction

    function automatic logic [63:0] mseed(input int c);
        return rotl(64'h0c45f864_04e4684a, (17 * c) % 64);
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_update(input int i);
        int   steps, w;
        bit   hs, wh, adv;
        logic [63:0]  t, msk;
        logic [191:0] v;
        steps = (i == 0) ? 1 : 4;
        hs    = (i == 0);
        wh    = (i == 1);
        w     = (i == 0) ? 64 : 48;
        if (reset) begin
            for (int c = 0; c < 3; c++) m_lfsr[i][c] = mseed(c);
            m_weyl[i] = 0;
            m_cnt[i]  = 0;
            m_vld[i]  = 0;
        end else if (seed_load && seed_chan < 2'd3) begin
            m_lfsr[i][seed_chan] = (seed_value == 64'd0) ? mseed(int'(seed_chan)) : seed_value;
            m_vld[i] = 0;
        end else begin
            adv = m_vld[i] && enable && (hs ? rand_ready : 1'b1);
            if (enable) m_vld[i] = 1;
            if (adv) begin
                for (int c = 0; c < 3; c++)
                    for (int k = 0; k < steps; k++) m_lfsr[i][c] = mul_x(m_lfsr[i][c]);
                m_cnt[i]  = m_cnt[i] + 1;
                m_weyl[i] = m_weyl[i] + 32'h9E3779B9;
            end
        end
        if (m_vld[i]) begin
            msk = wh ? {m_weyl[i], m_weyl[i]} : 64'd0;
            v   = '0;
            for (int c = 0; c < 3; c++) begin
                t = m_lfsr[i][c] ^ msk;
                if (w == 64) v[c*64 +: 64] = t;
                else         v[c*48 +: 48] = t[47:0];
            end
            if (i == 0) qa.push_back('{v: v, n: m_cnt[i]});
            else        qb.push_back('{v: v, n: m_cnt[i]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_valid === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_valid", {191'd0, a_valid}, 192'd0);
            end else begin
                e = qa.pop_front();
                check("a_vect", a_vect, e.v);
                check("a_count", {160'd0, a_cnt}, {160'd0, e.n});
            end
        end
        if (b_valid === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_valid", {191'd0, b_valid}, 192'd0);
            end else begin
                e = qb.pop_front();
                check("b_vect", {48'd0, b_vect}, e.v);
                check("b_count", {160'd0, b_cnt}, {160'd0, e.n});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; enable = 0; rand_ready = 0; seed_load = 0; seed_chan = 0; seed_value = 0;
        repeat (3) tick();
        check("reset_valid_a", {191'd0, a_valid}, 192'd0);
        check("reset_count_a", {160'd0, a_cnt}, 192'd0);

        reset = 0; enable = 1;
        tick();
        check("first_valid", {191'd0, a_valid}, 192'd1);
        check("first_ch0", {128'd0, a_vect[63:0]}, {128'd0, 64'h0c45f864_04e4684a});
        check("first_ch1", {128'd0, a_vect[127:64]}, {128'd0, rotl(64'h0c45f864_04e4684a, 17)});
        check("first_b_ch0", {144'd0, b_vect[47:0]}, {144'd0, 48'hf864_04e4684a});

        rand_ready = 1;
        tick();
        check("adv1_ch0", {128'd0, a_vect[63:0]}, {128'd0, 64'h188bf0c8_09c8d094});
        check("adv1_count", {160'd0, a_cnt}, 192'd1);

        seed_load = 1; seed_chan = 0; seed_value = 64'h8000_0000_0000_0000;
        tick();
        check("seed_valid_drop", {191'd0, a_valid}, 192'd0);
        seed_load = 0;
        tick();
        check("seed_valid_back", {191'd0, a_valid}, 192'd1);
        tick();
        check("seed_adv_ch0", {128'd0, a_vect[63:0]}, {128'd0, 64'h1B});
        check("seed_adv_count", {160'd0, a_cnt}, 192'd2);

        rand_ready = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hs_hold_count", {160'd0, a_cnt}, 192'd2);
            check("hs_hold_ch0", {128'd0, a_vect[63:0]}, {128'd0, 64'h1B});
        end
        rand_ready = 1;
        repeat (3) tick();
        check("hs_release_count", {160'd0, a_cnt}, 192'd5);

        seed_load = 1; seed_chan = 1; seed_value = 64'd0;
        tick();
        seed_load = 0;
        tick();
        check("zero_seed_ch1", {128'd0, a_vect[127:64]}, {128'd0, mseed(1)});

        seed_load = 1; seed_chan = 3; seed_value = 64'hdead_beef_0123_4567;
        tick();
        check("oor_valid", {191'd0, a_valid}, 192'd1);
        check("oor_count", {160'd0, a_cnt}, 192'd6);
        seed_load = 0;

        for (int k = 0; k < 300; k++) begin
            reset      = ($urandom_range(0, 49) == 0);
            enable     = ($urandom_range(0, 9) < 8);
            rand_ready = ($urandom_range(0, 9) < 6);
            seed_load  = ($urandom_range(0, 9) == 0);
            seed_chan  = 2'($urandom_range(0, 3));
            seed_value = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            tick();
        end

        reset = 0; enable = 1; rand_ready = 1; seed_load = 0;
        repeat (5) tick();
        reset = 1;
        tick();
        check("midreset_valid_b", {191'd0, b_valid}, 192'd0);
        check("midreset_count_b", {160'd0, b_cnt}, 192'd0);
        check("midreset_ch2_a", {128'd0, a_vect[191:128]}, {128'd0, mseed(2)});
        reset = 0;
        repeat (4) tick();

        @(negedge clk);
        #1;
        check("a_queue_drained", 192'(qa.size()), 192'd0);
        check("b_queue_drained", 192'(qb.size()), 192'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
